// File: rtl/sift_pkg.sv
// Shared types for the SIFT pyramid datapath: edge modes, fetcher states,
// tap indices and the read-tag record that travels alongside BRAM reads.
package sift_pkg;

  localparam int KERNEL_TAPS = 9;

  typedef enum logic {
    EDGE_CLAMP = 1'b0,
    EDGE_ZERO  = 1'b1
  } edge_mode_t;

  typedef logic [3:0] tap_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_PRESENT
  } fetcher_state_t;

  typedef struct packed {
    logic     valid;
    tap_idx_t idx;
    logic     zero;
  } tap_tag_t;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } tap_offset_t;

  localparam tap_idx_t LAST_TAP = tap_idx_t'(KERNEL_TAPS - 1);

  // Raster tap order: idx = 3*(ky+1) + (kx+1).
  function automatic tap_offset_t tap_offset(input tap_idx_t idx);
    tap_offset_t off;
    case (idx)
      4'd0, 4'd3, 4'd6: off.dx = -2'sd1;
      4'd1, 4'd4, 4'd7: off.dx = 2'sd0;
      default:          off.dx = 2'sd1;
    endcase
    if (idx < 4'd3)      off.dy = -2'sd1;
    else if (idx < 4'd6) off.dy = 2'sd0;
    else                 off.dy = 2'sd1;
    return off;
  endfunction

endpackage

// File: rtl/kernel_window_fetcher_tap_tag_pipe.sv
// Delay line that carries each read's tag so it lines up with the BRAM data
// READ_LATENCY cycles later.
module tap_tag_pipe
  import sift_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic     clk_in,
  input  logic     clear_in,
  input  tap_tag_t tag_in,
  output tap_tag_t tag_out
);

  tap_tag_t stage_q [READ_LATENCY];
  tap_tag_t stage_d [READ_LATENCY];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < READ_LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value on the same edge.
  always_ff @(posedge clk_in) begin
    if (clear_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/kernel_window_fetcher.sv
// 3x3 neighbourhood sequencer: walks every center of the selected octave,
// issues nine edge-handled tap reads, realigns the returned data and presents
// each window over valid/ready.
module kernel_window_fetcher
  import sift_pkg::*;
#(
  parameter int WIDTH        = 128,
  parameter int HEIGHT       = 128,
  parameter int BIT_DEPTH    = 8,
  parameter int OCTAVES      = 4,
  parameter int READ_LATENCY = 2,
  parameter int EDGE_MODE    = 0,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int AW = $clog2(WIDTH * HEIGHT),
  localparam int OW = (OCTAVES > 1) ? $clog2(OCTAVES) : 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [OW-1:0]          octave_in,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   rd_en_out,
  output logic [AW-1:0]          rd_addr_out,
  input  logic [BIT_DEPTH-1:0]   rd_data_in,
  output logic [3*BIT_DEPTH-1:0] r0_data_out,
  output logic [3*BIT_DEPTH-1:0] r1_data_out,
  output logic [3*BIT_DEPTH-1:0] r2_data_out,
  output logic                   window_valid_out,
  input  logic                   window_ready_in,
  output logic [XW-1:0]          center_x_out,
  output logic [YW-1:0]          center_y_out
);

  localparam edge_mode_t EMODE = (EDGE_MODE != 0) ? EDGE_ZERO : EDGE_CLAMP;
  // Sign bit plus one guard bit so x-1 and x+1 never alias.
  localparam int CW = ((XW > YW) ? XW : YW) + 2;

  if ((WIDTH >> (OCTAVES - 1)) < 2) begin : g_chk_width
    $error("kernel_window_fetcher: smallest octave narrower than 2 pixels");
  end
  if ((HEIGHT >> (OCTAVES - 1)) < 2) begin : g_chk_height
    $error("kernel_window_fetcher: smallest octave shorter than 2 pixels");
  end
  if (READ_LATENCY < 1) begin : g_chk_latency
    $error("kernel_window_fetcher: READ_LATENCY must be at least 1");
  end

  fetcher_state_t       state_q, state_d;
  tap_idx_t             tap_q, tap_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic [XW:0]          w_o_q, w_o_d;
  logic [YW:0]          h_o_q, h_o_d;
  logic                 done_q, done_d;
  logic [BIT_DEPTH-1:0] win_q [KERNEL_TAPS];
  logic [BIT_DEPTH-1:0] win_d [KERNEL_TAPS];

  tap_offset_t          off;
  logic signed [CW-1:0] tap_x, tap_y, lim_x, lim_y, clamp_x, clamp_y;
  logic                 oob, skip, fetching;
  logic [AW-1:0]        tap_addr;
  logic [OW-1:0]        oct_sel;
  logic                 last_x, last_y;
  tap_tag_t             tag_in, tag_out;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    off     = tap_offset(tap_q);
    lim_x   = $signed(CW'(w_o_q));
    lim_y   = $signed(CW'(h_o_q));
    tap_x   = $signed(CW'(x_q)) + $signed({{(CW-2){off.dx[1]}}, off.dx});
    tap_y   = $signed(CW'(y_q)) + $signed({{(CW-2){off.dy[1]}}, off.dy});
    oob     = (tap_x < 0) || (tap_x >= lim_x) || (tap_y < 0) || (tap_y >= lim_y);
    clamp_x = tap_x;
    clamp_y = tap_y;
    if (tap_x < 0)           clamp_x = '0;
    else if (tap_x >= lim_x) clamp_x = lim_x - CW'(1);
    if (tap_y < 0)           clamp_y = '0;
    else if (tap_y >= lim_y) clamp_y = lim_y - CW'(1);
    tap_addr = AW'($unsigned(clamp_y)) * AW'(w_o_q) + AW'($unsigned(clamp_x));
    fetching = (state_q == ST_FETCH);
    skip     = (EMODE == EDGE_ZERO) && oob;
  end

  assign tag_in = '{valid: fetching, idx: tap_q, zero: skip};

  tap_tag_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_tag_pipe (
    .clk_in   (clk_in),
    .clear_in (rst_in),
    .tag_in   (tag_in),
    .tag_out  (tag_out)
  );

  assign oct_sel = (int'(octave_in) >= OCTAVES) ? OW'(OCTAVES - 1) : octave_in;
  assign last_x  = ({1'b0, x_q} == w_o_q - 1'b1);
  assign last_y  = ({1'b0, y_q} == h_o_q - 1'b1);

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    x_d     = x_q;
    y_d     = y_q;
    w_o_d   = w_o_q;
    h_o_d   = h_o_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          w_o_d   = (XW+1)'(WIDTH >> oct_sel);
          h_o_d   = (YW+1)'(HEIGHT >> oct_sel);
          x_d     = '0;
          y_d     = '0;
          tap_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (tap_q == LAST_TAP) state_d = ST_DRAIN;
        else                   tap_d   = tap_q + 1'b1;
      end
      ST_DRAIN: begin
        if (tag_out.valid && tag_out.idx == LAST_TAP) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (window_ready_in) begin
          tap_d = '0;
          if (last_x && last_y) begin
            x_d     = '0;
            y_d     = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
            if (last_x) begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Returned data lands in the slot named by its tag; zero-flagged taps read 0.
  always_comb begin
    win_d = win_q;
    if (tag_out.valid) begin
      for (int i = 0; i < KERNEL_TAPS; i++) begin
        if (tag_out.idx == tap_idx_t'(i)) begin
          win_d[i] = tag_out.zero ? '0 : rd_data_in;
        end
      end
    end
  end

  // NOTE: the window registers are reset too, because the row outputs come
  // straight from them and must read 0 out of reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_o_q   <= '0;
      h_o_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < KERNEL_TAPS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_o_q   <= w_o_d;
      h_o_q   <= h_o_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  assign busy_out         = (state_q != ST_IDLE);
  assign done_out         = done_q;
  assign rd_en_out        = fetching && !skip;
  assign rd_addr_out      = (fetching && !skip) ? tap_addr : '0;
  assign window_valid_out = (state_q == ST_PRESENT);
  assign r0_data_out      = {win_q[0], win_q[1], win_q[2]};
  assign r1_data_out      = {win_q[3], win_q[4], win_q[5]};
  assign r2_data_out      = {win_q[6], win_q[7], win_q[8]};
  assign center_x_out     = x_q;
  assign center_y_out     = y_q;

endmodule

// File: tb/tb_kernel_window_fetcher.sv
// Directed bench for kernel_window_fetcher on an 8x8, two-octave image whose
// BRAM returns pixel = address; one clamp-mode and one zero-mode instance.
module tb_kernel_window_fetcher;

  localparam int W = 8, H = 8, BD = 8, OCT = 2, RL = 2;
  localparam int AW = 6, XW = 3, YW = 3, OW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_c, start_c, ready_c, busy_c, done_c, rd_en_c, valid_c;
  logic [OW-1:0]   oct_c;
  logic [AW-1:0]   rd_addr_c;
  logic [BD-1:0]   rd_data_c;
  logic [3*BD-1:0] r0_c, r1_c, r2_c;
  logic [XW-1:0]   cx_c;
  logic [YW-1:0]   cy_c;

  logic            rst_z, start_z, ready_z, busy_z, done_z, rd_en_z, valid_z;
  logic [OW-1:0]   oct_z;
  logic [AW-1:0]   rd_addr_z;
  logic [BD-1:0]   rd_data_z;
  logic [3*BD-1:0] r0_z, r1_z, r2_z;
  logic [XW-1:0]   cx_z;
  logic [YW-1:0]   cy_z;

  kernel_window_fetcher #(
    .WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD), .OCTAVES(OCT),
    .READ_LATENCY(RL), .EDGE_MODE(0)
  ) u_clamp (
    .clk_in(clk), .rst_in(rst_c), .start_in(start_c), .octave_in(oct_c),
    .busy_out(busy_c), .done_out(done_c), .rd_en_out(rd_en_c),
    .rd_addr_out(rd_addr_c), .rd_data_in(rd_data_c),
    .r0_data_out(r0_c), .r1_data_out(r1_c), .r2_data_out(r2_c),
    .window_valid_out(valid_c), .window_ready_in(ready_c),
    .center_x_out(cx_c), .center_y_out(cy_c)
  );

  kernel_window_fetcher #(
    .WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD), .OCTAVES(OCT),
    .READ_LATENCY(RL), .EDGE_MODE(1)
  ) u_zero (
    .clk_in(clk), .rst_in(rst_z), .start_in(start_z), .octave_in(oct_z),
    .busy_out(busy_z), .done_out(done_z), .rd_en_out(rd_en_z),
    .rd_addr_out(rd_addr_z), .rd_data_in(rd_data_z),
    .r0_data_out(r0_z), .r1_data_out(r1_z), .r2_data_out(r2_z),
    .window_valid_out(valid_z), .window_ready_in(ready_z),
    .center_x_out(cx_z), .center_y_out(cy_z)
  );

  // Two-stage BRAM models; 8'hEE marks a cycle with no read enable.
  logic [BD-1:0] bram_c0, bram_c1, bram_z0, bram_z1;
  always @(posedge clk) begin
    bram_c0 <= rd_en_c ? BD'(rd_addr_c) : 8'hEE;
    bram_c1 <= bram_c0;
    bram_z0 <= rd_en_z ? BD'(rd_addr_z) : 8'hEE;
    bram_z1 <= bram_z0;
  end
  assign rd_data_c = bram_c1;
  assign rd_data_z = bram_z1;

  typedef struct {
    int          cyc;
    int          cx;
    int          cy;
    logic [23:0] r0, r1, r2;
  } xfer_t;

  xfer_t xq[$];
  int    cyc = 0, done_cnt = 0, rden_z_cnt = 0;
  int    errors = 0, checks = 0;

  // Monitor samples 1 ns after the falling edge, once inputs have settled.
  always begin
    xfer_t x;
    @(negedge clk);
    #1;
    cyc++;
    if (valid_c && ready_c) begin
      x.cyc = cyc;
      x.cx  = int'(cx_c);
      x.cy  = int'(cy_c);
      x.r0  = r0_c;
      x.r1  = r1_c;
      x.r2  = r2_c;
      xq.push_back(x);
    end
    if (done_c)  done_cnt++;
    if (rd_en_z) rden_z_cnt++;
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] row3(input int a, input int b, input int c);
    return {8'(a), 8'(b), 8'(c)};
  endfunction

  task automatic check_xfer(input string tag, input xfer_t x, input int ex, input int ey,
                            input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2);
    check({tag, "_cx"}, 80'(x.cx), 80'(ex));
    check({tag, "_cy"}, 80'(x.cy), 80'(ey));
    check({tag, "_rows"}, {8'h0, x.r0, x.r1, x.r2}, {8'h0, e0, e1, e2});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    rst_c = 1'b1; rst_z = 1'b1; start_c = 1'b0; start_z = 1'b0;
    oct_c = '0; oct_z = '0; ready_c = 1'b0; ready_z = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busy",  busy_c, 0);
    check("rst_done",  done_c, 0);
    check("rst_rden",  rd_en_c, 0);
    check("rst_addr",  rd_addr_c, 0);
    check("rst_valid", valid_c, 0);
    check("rst_rows",  {r0_c, r1_c, r2_c}, 0);
    check("rst_center", {cx_c, cy_c}, 0);
    check("rst_valid_z", valid_z, 0);

    // Clamp and zero instances start together, ready held low.
    rst_c = 1'b0; rst_z = 1'b0;
    @(negedge clk);
    start_c = 1'b1; start_z = 1'b1;
    @(negedge clk);
    start_c = 1'b0; start_z = 1'b0;
    j = 1;
    check("busy_rise", busy_c, 1);
    check("tap0_rden", rd_en_c, 1);
    check("tap0_addr", rd_addr_c, 0);
    check("zero_tap0_rden", rd_en_z, 0);
    while (!valid_c && j < 40) begin
      @(negedge clk);
      j++;
    end
    check("first_valid_cycle", j, 12);
    check("clamp00_rows", {r0_c, r1_c, r2_c}, {row3(0,0,1), row3(0,0,1), row3(8,8,9)});
    check("clamp00_center", {cx_c, cy_c}, 0);
    check("zero00_valid", valid_z, 1);
    check("zero00_rows", {r0_z, r1_z, r2_z}, {row3(0,0,0), row3(0,0,1), row3(0,8,9)});
    check("zero00_rden_pulses", rden_z_cnt, 4);

    // Backpressure: ready low for 5 more cycles in PRESENT.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", valid_c, 1);
      check("stall_rden", rd_en_c, 0);
      check("stall_rows", {r0_c, r1_c, r2_c}, {row3(0,0,1), row3(0,0,1), row3(8,8,9)});
      check("stall_center", {cx_c, cy_c}, 0);
    end
    ready_c = 1'b1;

    // Full octave-0 pass with a start pulse mid-pass that must be ignored.
    j = 0;
    while (!done_c && j < 2000) begin
      @(negedge clk);
      j++;
      if (j == 30) begin
        start_c = 1'b1; oct_c = 1'b1;
      end else if (j == 31) begin
        start_c = 1'b0; oct_c = 1'b0;
      end
    end
    start_c = 1'b0; oct_c = 1'b0;
    check("oct0_done_seen", done_c, 1);
    check("oct0_busy_at_done", busy_c, 0);
    repeat (3) @(negedge clk);
    check("oct0_done_pulses", done_cnt, 1);
    check("oct0_windows", xq.size(), 64);
    if (xq.size() >= 64) begin
      check_xfer("oct0_w0", xq[0], 0, 0, row3(0,0,1), row3(0,0,1), row3(8,8,9));
      check_xfer("oct0_w1", xq[1], 1, 0, row3(0,1,2), row3(0,1,2), row3(8,9,10));
      check_xfer("oct0_w8", xq[8], 0, 1, row3(0,0,1), row3(8,8,9), row3(16,16,17));
      check_xfer("oct0_w63", xq[63], 7, 7, row3(54,55,55), row3(62,63,63), row3(62,63,63));
      check("period_w0_w1", xq[1].cyc - xq[0].cyc, 12);
      check("period_w1_w2", xq[2].cyc - xq[1].cyc, 12);
    end

    // Octave 1 (4x4) pass in clamp mode, ready held high.
    xq.delete();
    done_cnt = 0;
    start_c = 1'b1; oct_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0; oct_c = 1'b0;
    j = 0;
    while (!done_c && j < 1000) begin
      @(negedge clk);
      j++;
    end
    check("oct1_done_seen", done_c, 1);
    repeat (3) @(negedge clk);
    check("oct1_done_pulses", done_cnt, 1);
    check("oct1_windows", xq.size(), 16);
    if (xq.size() >= 16) begin
      check_xfer("oct1_w0", xq[0], 0, 0, row3(0,0,1), row3(0,0,1), row3(4,4,5));
      check_xfer("oct1_w15", xq[15], 3, 3, row3(10,11,11), row3(14,15,15), row3(14,15,15));
    end

    // Reset in the middle of FETCH, then a clean restart.
    ready_c = 1'b0;
    start_c = 1'b1; oct_c = 1'b0;
    @(negedge clk);
    start_c = 1'b0;
    repeat (2) @(negedge clk);
    check("prerst_busy", busy_c, 1);
    rst_c = 1'b1;
    @(negedge clk);
    check("midrst_busy",  busy_c, 0);
    check("midrst_done",  done_c, 0);
    check("midrst_rden",  rd_en_c, 0);
    check("midrst_addr",  rd_addr_c, 0);
    check("midrst_valid", valid_c, 0);
    check("midrst_rows",  {r0_c, r1_c, r2_c}, 0);
    check("midrst_center", {cx_c, cy_c}, 0);
    rst_c = 1'b0;
    @(negedge clk);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    j = 1;
    while (!valid_c && j < 40) begin
      @(negedge clk);
      j++;
    end
    check("restart_valid_cycle", j, 12);
    check("restart_rows", {r0_c, r1_c, r2_c}, {row3(0,0,1), row3(0,0,1), row3(8,8,9)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
